// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller for an external register file with a combinational read port.
// Optional sticky error flags (overflow/underflow) are added when FIFO_CTRL_ERR_FLAGS_EN is defined.
module fifo_ctrl #(
  parameter int addr_width = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [addr_width-1:0] w_addr,
  output logic [addr_width-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic [addr_width:0]   count
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [addr_width:0] L_DEPTH = (addr_width+1)'(2**addr_width);

  logic [addr_width-1:0] r_wptr;
  logic [addr_width-1:0] r_rptr;
  logic [addr_width:0]   r_cnt;
  logic                  r_full;
  logic                  r_empty;

  logic                  w_wa;
  logic                  w_ra;
  logic [addr_width:0]   w_cnt_next;

  // A write while full is still taken when a pop frees the slot in the same cycle.
  assign w_wa = wr & (~r_full | rd);
  assign w_ra = rd & ~r_empty;

  always_comb begin
    w_cnt_next = r_cnt;
    case ({w_wa, w_ra})
      2'b10:   w_cnt_next = r_cnt + (addr_width+1)'(1);
      2'b01:   w_cnt_next = r_cnt - (addr_width+1)'(1);
      default: w_cnt_next = r_cnt;
    endcase
  end

  // Flags come from the next count so they line up with the updated pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wa) r_wptr <= r_wptr + addr_width'(1);
      if (w_ra) r_rptr <= r_rptr + addr_width'(1);
      r_cnt   <= w_cnt_next;
      r_full  <= (w_cnt_next == L_DEPTH);
      r_empty <= (w_cnt_next == '0);
    end
  end

  assign w_en   = w_wa & rst_n;
  assign w_addr = r_wptr;
  assign r_addr = r_rptr;
  assign count  = r_cnt;
  assign full   = r_full;
  assign empty  = r_empty;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr & r_full & ~rd) r_overflow  <= 1'b1;
      if (rd & r_empty)      r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios plus randomized traffic against a queue model.
// Define FIFO_CTRL_ERR_FLAGS_EN for both files to also check the sticky error flags.
module tb_fifo_ctrl;
  localparam int AW    = 5;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          rst_n, wr, rd;
  logic          w_en, full, empty;
  logic [AW-1:0] w_addr, r_addr;
  logic [AW:0]   count;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  fifo_ctrl #(.addr_width(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .w_en(w_en),
    .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty), .count(count)
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  // Register file owned by the bench: written through w_en/w_addr, read combinationally at r_addr.
  logic [7:0] mem [0:DEPTH-1];
  logic [7:0] din;
  always @(posedge clk) if (w_en) mem[w_addr] <= din;

  // Reference model: a data queue plus pointer counters and sticky flags.
  logic [7:0] q[$];
  int  exp_wp, exp_rp;
  bit  exp_ov, exp_un, exp_wa, exp_ra;
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic drive(input bit w, input bit r, input bit rs);
    wr = w; rd = r; rst_n = rs; din = 8'($urandom);
    #1;
    exp_wa = rs && w && ((q.size() < DEPTH) || r);
    exp_ra = rs && r && (q.size() > 0);
  endtask

  task automatic tick();
    bit was_full, was_empty;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    @(posedge clk); #1;
    if (!rst_n) begin
      q.delete(); exp_wp = 0; exp_rp = 0; exp_ov = 0; exp_un = 0;
    end else begin
      if (wr && was_full && !rd) exp_ov = 1;
      if (rd && was_empty)       exp_un = 1;
      if (exp_ra) begin void'(q.pop_front()); exp_rp = (exp_rp + 1) % DEPTH; end
      if (exp_wa) begin q.push_back(din);     exp_wp = (exp_wp + 1) % DEPTH; end
    end
  endtask

  task automatic test_reset();
    drive(0, 0, 0); tick();
    drive(1, 1, 0);
    n_tests++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL reset_w_en: got %b want 0", w_en); end
    tick();
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if (w_addr !== '0 || r_addr !== '0) begin n_fail++; $display("FAIL reset_ptrs: got w=%0d r=%0d want 0/0", w_addr, r_addr); end
    drive(0, 0, 1);
    n_tests++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL idle_w_en: got %b want 0", w_en); end
    tick();
    $display("[TB] test_reset done");
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 1);
      n_tests++; if (w_en !== 1'b1) begin n_fail++; $display("FAIL fill_w_en[%0d]: got %b want 1", i, w_en); end
      tick();
      n_tests++; if (count !== (AW+1)'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
    end
    n_tests++; if (full !== 1'b1 || count !== (AW+1)'(32) || w_addr !== '0) begin
      n_fail++; $display("FAIL fill_full: got full=%b count=%0d w_addr=%0d want 1/32/0", full, count, w_addr);
    end
    drive(1, 0, 1);
    n_tests++; if (w_en !== 1'b0) begin n_fail++; $display("FAIL overfill_w_en: got %b want 0", w_en); end
    tick();
    n_tests++; if (count !== (AW+1)'(32) || w_addr !== '0) begin n_fail++; $display("FAIL overfill_state: got count=%0d w_addr=%0d want 32/0", count, w_addr); end
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b want 1", overflow); end
`endif
    $display("[TB] test_fill done");
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 1);
      n_tests++; if (mem[r_addr] !== q[0]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, mem[r_addr], q[0]); end
      tick();
    end
    n_tests++; if (empty !== 1'b1 || r_addr !== '0 || count !== '0) begin
      n_fail++; $display("FAIL drain_empty: got empty=%b r_addr=%0d count=%0d want 1/0/0", empty, r_addr, count);
    end
    drive(0, 1, 1); tick();
    n_tests++; if (count !== '0 || r_addr !== '0) begin n_fail++; $display("FAIL underread: got count=%0d r_addr=%0d want 0/0", count, r_addr); end
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_set: got %b want 1", underflow); end
`endif
    $display("[TB] test_drain done");
  endtask

  task automatic test_simul();
    drive(1, 1, 1);
    n_tests++; if (w_en !== 1'b1) begin n_fail++; $display("FAIL simul_empty_w_en: got %b want 1", w_en); end
    tick();
    n_tests++; if (count !== (AW+1)'(1) || r_addr !== '0 || w_addr !== AW'(1)) begin
      n_fail++; $display("FAIL simul_empty: got count=%0d r=%0d w=%0d want 1/0/1", count, r_addr, w_addr);
    end
    repeat (4) begin drive(1, 0, 1); tick(); end
    drive(1, 1, 1);
    n_tests++; if (mem[r_addr] !== q[0]) begin n_fail++; $display("FAIL simul5_data: got %h want %h", mem[r_addr], q[0]); end
    tick();
    n_tests++; if (count !== (AW+1)'(5) || w_addr !== AW'(6) || r_addr !== AW'(1)) begin
      n_fail++; $display("FAIL simul5: got count=%0d w=%0d r=%0d want 5/6/1", count, w_addr, r_addr);
    end
    repeat (27) begin drive(1, 0, 1); tick(); end
    drive(1, 1, 1);
    n_tests++; if (w_en !== 1'b1) begin n_fail++; $display("FAIL simul_full_w_en: got %b want 1", w_en); end
    tick();
    n_tests++; if (count !== (AW+1)'(32) || full !== 1'b1 || empty !== 1'b0 || w_addr !== AW'(2) || r_addr !== AW'(2)) begin
      n_fail++; $display("FAIL simul_full: got count=%0d full=%b empty=%b w=%0d r=%0d want 32/1/0/2/2", count, full, empty, w_addr, r_addr);
    end
    $display("[TB] test_simul done");
  endtask

  task automatic test_midreset();
    drive(0, 0, 0); tick();
    repeat (17) begin drive(1, 0, 1); tick(); end
    n_tests++; if (count !== (AW+1)'(17)) begin n_fail++; $display("FAIL midreset_pre: got count=%0d want 17", count); end
    drive(1, 1, 0); tick();
    n_tests++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || w_addr !== '0 || r_addr !== '0) begin
      n_fail++; $display("FAIL midreset: got count=%0d empty=%b full=%b w=%0d r=%0d want 0/1/0/0/0", count, empty, full, w_addr, r_addr);
    end
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    n_tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got ov=%b un=%b want 0/0", overflow, underflow); end
`endif
    $display("[TB] test_midreset done");
  endtask

  task automatic test_random();
    int wp, rp, errs_before;
    errs_before = n_fail;
    for (int c = 0; c < 10000; c++) begin
      if (c % 1000 == 0) begin wp = $urandom_range(20, 80); rp = $urandom_range(20, 80); end
      drive($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 1);
      n_tests++; if (w_en !== exp_wa) begin n_fail++; $display("FAIL rand_w_en[%0d]: got %b want %b", c, w_en, exp_wa); end
      if (exp_ra) begin
        n_tests++; if (mem[r_addr] !== q[0]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", c, mem[r_addr], q[0]); end
      end
      tick();
      n_tests++;
      if (count !== (AW+1)'(q.size()) || full !== (q.size() == DEPTH) || empty !== (q.size() == 0) ||
          w_addr !== AW'(exp_wp) || r_addr !== AW'(exp_rp)) begin
        n_fail++; $display("FAIL rand_state[%0d]: got count=%0d full=%b empty=%b w=%0d r=%0d want %0d/%b/%b/%0d/%0d",
          c, count, full, empty, w_addr, r_addr, q.size(), q.size() == DEPTH, q.size() == 0, exp_wp, exp_rp);
      end
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      n_tests++; if (overflow !== exp_ov || underflow !== exp_un) begin
        n_fail++; $display("FAIL rand_flags[%0d]: got ov=%b un=%b want %b/%b", c, overflow, underflow, exp_ov, exp_un);
      end
`endif
    end
    $display("[TB] test_random done, %0d new failures", n_fail - errs_before);
  endtask

  initial begin
    wr = 0; rd = 0; rst_n = 0; din = '0;
    exp_wp = 0; exp_rp = 0; exp_ov = 0; exp_un = 0;
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_drain();
    test_simul();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
